// File: rtl/ocr_pkg.sv
// Shared types, status/command codes and the 7-segment glyph decoder
// for the OCR frame controller.
package ocr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        INFER,
        RESULT,
        ERROR
    } state_t;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_RECV    = 4'd1;
    localparam logic [3:0] ST_INFER   = 4'd2;
    localparam logic [3:0] ST_RESULT  = 4'd3;
    localparam logic [3:0] ST_ERR_OP  = 4'd4;
    localparam logic [3:0] ST_ERR_TO  = 4'd5;
    localparam logic [3:0] ST_ERR_CLS = 4'd6;

    localparam logic [7:0] CMD_IMG   = 8'h01;
    localparam logic [7:0] CMD_CLEAR = 8'h02;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit order gfedcba; anything outside 0-9 is blank.
    function automatic logic [6:0] seg7_decode(input logic [3:0] val);
        case (val)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: one digit lit at a time, advancing every
// SCAN_DIV cycles; segment and anode registers always update together.
module seg7_scan
    import ocr_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIGITS-1:0][6:0] i_digit_seg,
    output logic [6:0]             o_seg,
    output logic [DIGITS-1:0]      o_an
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]  r_scan_cnt;
    logic [IDX_W-1:0]  r_digit_idx;
    logic [6:0]        r_seg;
    logic [DIGITS-1:0] r_an;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
            r_seg       <= SEG_BLANK;
            r_an        <= ~DIGITS'(1);
        end else begin
            if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
                r_scan_cnt  <= '0;
                r_digit_idx <= (r_digit_idx == IDX_W'(DIGITS - 1)) ? '0
                                                                   : r_digit_idx + IDX_W'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + CNT_W'(1);
            end
            r_seg <= i_digit_seg[r_digit_idx];
            r_an  <= ~(DIGITS'(1) << r_digit_idx);
        end
    end

    assign o_seg = r_seg;
    assign o_an  = r_an;

endmodule

// File: rtl/ocr_frame_controller.sv
// Frame/command sequencer for the BNN OCR datapath: parses SPI opcodes,
// streams one image into the buffer, runs inference and reports the result.
module ocr_frame_controller
    import ocr_pkg::*;
#(
    parameter  int IMG_BITS       = 900,
    parameter  int RESULT_W       = 4,
    parameter  int NUM_CLASSES    = 10,
    parameter  int DIGITS         = 2,
    parameter  int SCAN_DIV       = 50000,
    parameter  int HB_DIV         = 25000000,
    parameter  int TIMEOUT_CYCLES = 1000000,
    localparam int NUM_BYTES      = (IMG_BITS + 7) / 8,
    localparam int ADDR_W         = $clog2(NUM_BYTES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_byte,
    input  logic                rx_valid,
    output logic                rx_enable,
    output logic                rx_taken,
    output logic                buf_wr_en,
    output logic [ADDR_W-1:0]   buf_wr_addr,
    output logic [7:0]          buf_wr_data,
    output logic                buf_clear,
    output logic                bnn_start,
    input  logic                bnn_done,
    input  logic [RESULT_W-1:0] bnn_result,
    output logic                result_valid,
    output logic [3:0]          status_code,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic                heartbeat
);

    localparam int               PAD_BITS  = 8 * NUM_BYTES - IMG_BITS;
    localparam logic [7:0]       LAST_MASK = 8'(8'hFF << PAD_BITS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);
    localparam int               TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int               HB_W      = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

    state_t                r_state;
    logic [3:0]            r_status;
    logic                  r_rx_taken;
    logic                  r_buf_wr_en;
    logic [ADDR_W-1:0]     r_buf_wr_addr;
    logic [7:0]            r_buf_wr_data;
    logic                  r_buf_clear;
    logic                  r_bnn_start;
    logic [RESULT_W-1:0]   r_result;
    logic                  r_result_valid;
    logic                  r_heartbeat;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_last_written;
    logic [TO_W-1:0]       r_to_cnt;
    logic [HB_W-1:0]       r_hb_cnt;

    logic                  w_accept;
    logic                  w_timeout;
    logic [DIGITS-1:0][6:0] w_digit_seg;

    // A byte cannot be accepted in its own rx_taken cycle: the producer has
    // not yet had a chance to drop rx_valid.
    assign rx_enable = (r_state != INFER);
    assign w_accept  = rx_valid & rx_enable & ~r_rx_taken;
    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_status       <= ST_IDLE;
            r_rx_taken     <= 1'b0;
            r_buf_wr_en    <= 1'b0;
            r_buf_wr_addr  <= '0;
            r_buf_wr_data  <= '0;
            r_buf_clear    <= 1'b0;
            r_bnn_start    <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_heartbeat    <= 1'b0;
            r_addr         <= '0;
            r_last_written <= 1'b0;
            r_to_cnt       <= '0;
            r_hb_cnt       <= '0;
        end else begin
            r_rx_taken  <= w_accept;
            r_buf_wr_en <= 1'b0;
            r_buf_clear <= 1'b0;
            r_bnn_start <= 1'b0;

            if (r_hb_cnt == HB_W'(HB_DIV - 1)) begin
                r_hb_cnt    <= '0;
                r_heartbeat <= ~r_heartbeat;
            end else begin
                r_hb_cnt <= r_hb_cnt + HB_W'(1);
            end

            case (r_state)
                IDLE, RESULT, ERROR: begin
                    r_to_cnt <= '0;
                    if (w_accept) begin
                        if (rx_byte == CMD_IMG) begin
                            r_buf_clear    <= 1'b1;
                            r_result_valid <= 1'b0;
                            r_addr         <= '0;
                            r_last_written <= 1'b0;
                            r_state        <= RECV;
                            r_status       <= ST_RECV;
                        end else if (rx_byte == CMD_CLEAR) begin
                            r_buf_clear    <= 1'b1;
                            r_result_valid <= 1'b0;
                            r_state        <= IDLE;
                            r_status       <= ST_IDLE;
                        end else if (r_state != ERROR) begin
                            r_state  <= ERROR;
                            r_status <= ST_ERR_OP;
                        end
                    end
                end

                RECV: begin
                    if (r_last_written) begin
                        r_last_written <= 1'b0;
                        r_bnn_start    <= 1'b1;
                        r_to_cnt       <= '0;
                        r_state        <= INFER;
                        r_status       <= ST_INFER;
                    end else if (w_accept) begin
                        r_to_cnt      <= '0;
                        r_buf_wr_en   <= 1'b1;
                        r_buf_wr_addr <= r_addr;
                        r_addr        <= r_addr + ADDR_W'(1);
                        if (r_addr == LAST_ADDR) begin
                            r_buf_wr_data  <= rx_byte & LAST_MASK;
                            r_last_written <= 1'b1;
                        end else begin
                            r_buf_wr_data <= rx_byte;
                        end
                    end else if (w_timeout) begin
                        r_buf_clear <= 1'b1;
                        r_state     <= ERROR;
                        r_status    <= ST_ERR_TO;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                INFER: begin
                    // A completion landing on the expiry cycle still counts.
                    if (bnn_done) begin
                        r_result <= bnn_result;
                        if (32'(bnn_result) >= NUM_CLASSES) begin
                            r_state  <= ERROR;
                            r_status <= ST_ERR_CLS;
                        end else begin
                            r_result_valid <= 1'b1;
                            r_state        <= RESULT;
                            r_status       <= ST_RESULT;
                        end
                    end else if (w_timeout) begin
                        r_buf_clear <= 1'b1;
                        r_state     <= ERROR;
                        r_status    <= ST_ERR_TO;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_status <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        for (int d = 0; d < DIGITS; d++) begin
            w_digit_seg[d] = SEG_BLANK;
        end
        w_digit_seg[0] = r_result_valid ? seg7_decode(4'(r_result)) : SEG_BLANK;
        w_digit_seg[1] = seg7_decode(r_status);
    end

    seg7_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_seg7_scan (
        .clk         (clk),
        .rst         (rst),
        .i_digit_seg (w_digit_seg),
        .o_seg       (seg),
        .o_an        (an)
    );

    assign rx_taken     = r_rx_taken;
    assign buf_wr_en    = r_buf_wr_en;
    assign buf_wr_addr  = r_buf_wr_addr;
    assign buf_wr_data  = r_buf_wr_data;
    assign buf_clear    = r_buf_clear;
    assign bnn_start    = r_bnn_start;
    assign result_valid = r_result_valid;
    assign status_code  = r_status;
    assign heartbeat    = r_heartbeat;

endmodule

// File: tb/tb_ocr_frame_controller.sv
// Directed/randomized bench for ocr_frame_controller: frame streaming, result
// capture, opcode errors, timeout, mid-frame reset and display scanning.
module tb_ocr_frame_controller;

    localparam int IMG_BITS       = 900;
    localparam int NUM_BYTES      = 113;
    localparam int ADDR_W         = 7;
    localparam int RESULT_W       = 4;
    localparam int NUM_CLASSES    = 10;
    localparam int DIGITS         = 2;
    localparam int SCAN_DIV       = 4;
    localparam int HB_DIV         = 16;
    localparam int TIMEOUT_CYCLES = 1000;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [7:0]          rx_byte = 8'h00;
    logic                rx_valid = 1'b0;
    logic                bnn_done = 1'b0;
    logic [RESULT_W-1:0] bnn_result = '0;
    logic                rx_enable, rx_taken, buf_wr_en, buf_clear, bnn_start;
    logic                result_valid, heartbeat;
    logic [ADDR_W-1:0]   buf_wr_addr;
    logic [7:0]          buf_wr_data;
    logic [3:0]          status_code;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;

    ocr_frame_controller #(
        .IMG_BITS       (IMG_BITS),
        .RESULT_W       (RESULT_W),
        .NUM_CLASSES    (NUM_CLASSES),
        .DIGITS         (DIGITS),
        .SCAN_DIV       (SCAN_DIV),
        .HB_DIV         (HB_DIV),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_enable    (rx_enable),
        .rx_taken     (rx_taken),
        .buf_wr_en    (buf_wr_en),
        .buf_wr_addr  (buf_wr_addr),
        .buf_wr_data  (buf_wr_data),
        .buf_clear    (buf_clear),
        .bnn_start    (bnn_start),
        .bnn_done     (bnn_done),
        .bnn_result   (bnn_result),
        .result_valid (result_valid),
        .status_code  (status_code),
        .seg          (seg),
        .an           (an),
        .heartbeat    (heartbeat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Event log filled at the falling edge; the stimulus samples 1 ns later.
    int         cyc = 0;
    int         n_wr = 0, n_clear = 0, n_start = 0, n_taken = 0;
    int         wr_cyc = 0, clear_cyc = 0, start_cyc = 0, taken_cyc = 0;
    logic [ADDR_W-1:0] wr_addr [0:1023];
    logic [7:0]        wr_data [0:1023];
    logic [7:0]        sent    [0:NUM_BYTES-1];
    logic [6:0]        glyph   [0:15];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (buf_wr_en && n_wr < 1024) begin
                wr_addr[n_wr] = buf_wr_addr;
                wr_data[n_wr] = buf_wr_data;
                wr_cyc = cyc;
                n_wr++;
            end
            if (buf_clear) begin n_clear++; clear_cyc = cyc; end
            if (bnn_start) begin n_start++; start_cyc = cyc; end
            if (rx_taken)  begin n_taken++; taken_cyc = cyc; end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Image bit k of byte i sits at bit (7-k); bits past IMG_BITS must read as 0.
    function automatic logic [7:0] exp_byte(input int idx, input logic [7:0] b);
        logic [7:0] r;
        r = b;
        for (int k = 0; k < 8; k++) begin
            if (idx * 8 + k >= IMG_BITS) r[7-k] = 1'b0;
        end
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        rx_byte  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (rx_taken) got = 1'b1;
        end
        rx_valid = 1'b0;
        if (!got) check("rx_taken_wait", got, 1);
    endtask

    task automatic send_data(input int nbytes, input bit last_ff);
        for (int i = 0; i < nbytes; i++) begin
            sent[i] = 8'($urandom_range(0, 255));
            if (last_ff && i == nbytes - 1) sent[i] = 8'hFF;
            send_byte(sent[i]);
        end
    endtask

    task automatic check_frame(input int base);
        check("frame_write_count", n_wr - base, NUM_BYTES);
        for (int i = 0; i < NUM_BYTES; i++) begin
            check("frame_addr", wr_addr[base+i], i);
            check("frame_data", wr_data[base+i], exp_byte(i, sent[i]));
        end
    endtask

    task automatic wait_start();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (bnn_start) got = 1'b1;
        end
        check("bnn_start_seen", got, 1);
    endtask

    task automatic finish_infer(input logic [RESULT_W-1:0] res);
        bnn_result = res;
        bnn_done   = 1'b1;
        tick();
        bnn_done = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_status"}, status_code, 0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_seg"}, seg, 7'h7F);
        check({tag, "_an"}, an, 2'b10);
        check({tag, "_heartbeat"}, heartbeat, 0);
        check({tag, "_strobes"}, {buf_wr_en, buf_clear, bnn_start, rx_taken}, 4'b0000);
        check({tag, "_rx_enable"}, rx_enable, 1);
    endtask

    initial begin
        int base, clr0, tk0, wr0, st0, hb_len, res;
        bit got;
        logic [DIGITS-1:0] a0, exp_an;
        logic hb0;

        glyph[0] = 7'h40; glyph[1] = 7'h79; glyph[2] = 7'h24; glyph[3] = 7'h30;
        glyph[4] = 7'h19; glyph[5] = 7'h12; glyph[6] = 7'h02; glyph[7] = 7'h78;
        glyph[8] = 7'h00; glyph[9] = 7'h10;
        for (int g = 10; g < 16; g++) glyph[g] = 7'h7F;

        // Reset state
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Heartbeat half-period
        hb0 = heartbeat;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin tick(); if (heartbeat !== hb0) got = 1'b1; end
        hb0 = heartbeat;
        hb_len = 0;
        for (int k = 0; k < 40 && heartbeat === hb0; k++) begin tick(); hb_len++; end
        check("heartbeat_period", hb_len, HB_DIV);

        // 1: full frame, last byte 0xFF
        base = n_wr; clr0 = n_clear; st0 = n_start;
        send_byte(8'h01);
        check("img_status_recv", status_code, 1);
        send_data(NUM_BYTES, 1'b1);
        wait_start();
        check("frame1_clear_count", n_clear - clr0, 1);
        check_frame(base);
        check("frame1_last_data", wr_data[base+NUM_BYTES-1], 8'hF0);
        check("frame1_start_count", n_start - st0, 1);
        check("frame1_start_latency", start_cyc - wr_cyc, 1);
        check("frame1_status_infer", status_code, 2);
        check("frame1_rx_enable", rx_enable, 0);

        // 2: result 7, display scan
        finish_infer(4'd7);
        check("res7_valid", result_valid, 1);
        check("res7_status", status_code, 3);
        a0 = an;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin tick(); if (an !== a0) got = 1'b1; end
        check("scan_advance", got, 1);
        a0 = an;
        for (int k = 0; k < 16; k++) begin
            exp_an = (((k / 4) % 2) == 0) ? a0 : ~a0;
            check("scan_an", an, exp_an);
            check("scan_seg", seg, (exp_an == 2'b10) ? glyph[7] : glyph[3]);
            tick();
        end

        // 3: back to IDLE, bad opcode, then clear
        send_byte(8'h02);
        check("clear_status_idle", status_code, 0);
        check("clear_result_valid", result_valid, 0);
        wr0 = n_wr; tk0 = n_taken; clr0 = n_clear;
        send_byte(8'h5A);
        check("badop_status", status_code, 4);
        check("badop_taken", n_taken - tk0, 1);
        send_byte(8'h02);
        check("badop_clear_status", status_code, 0);
        check("badop_clear_pulse", n_clear - clr0, 1);
        check("badop_taken2", n_taken - tk0, 2);
        check("badop_no_write", n_wr - wr0, 0);

        // 4: short frame then silence -> timeout
        send_byte(8'h01);
        send_data(50, 1'b0);
        clr0 = n_clear;
        got = 1'b0;
        for (int k = 0; k < TIMEOUT_CYCLES + 100 && !got; k++) begin
            tick();
            if (buf_clear) got = 1'b1;
        end
        check("timeout_seen", got, 1);
        check("timeout_latency", clear_cyc - taken_cyc, TIMEOUT_CYCLES);
        check("timeout_clear_count", n_clear - clr0, 1);
        check("timeout_status", status_code, 5);
        wr0 = n_wr;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(3, 255)));
        check("err_ignore_status", status_code, 5);
        check("err_ignore_no_write", n_wr - wr0, 0);

        // 5: reset mid-frame
        send_byte(8'h01);
        check("restart_status", status_code, 1);
        send_data(60, 1'b0);
        wr0 = n_wr;
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick();
        check("midrst_no_write", n_wr - wr0, 0);
        base = n_wr;
        send_byte(8'h01);
        send_data(NUM_BYTES, 1'b0);
        wait_start();
        check_frame(base);
        res = $urandom_range(0, NUM_CLASSES - 1);
        finish_infer(RESULT_W'(res));
        check("res_rand_valid", result_valid, 1);
        check("res_rand_status", status_code, 3);

        // 6: byte held during INFER, out-of-range class
        send_byte(8'h01);
        send_data(NUM_BYTES, 1'b0);
        wait_start();
        tk0 = n_taken; clr0 = n_clear;
        rx_byte  = 8'h02;
        rx_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("infer_rx_enable", rx_enable, 0);
            check("infer_no_taken", rx_taken, 0);
        end
        finish_infer(4'd12);
        check("cls_status", status_code, 6);
        check("cls_result_valid", result_valid, 0);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin tick(); if (rx_taken) got = 1'b1; end
        rx_valid = 1'b0;
        check("held_byte_taken", got, 1);
        check("held_byte_taken_once", n_taken - tk0, 1);
        check("held_byte_clear", n_clear - clr0, 1);
        check("held_byte_status", status_code, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
